// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Purpose : Shared widths, alu opcodes and arbiter state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int c_OP_W  = 4;
  localparam int c_OPC_W = 3;
  localparam int c_RES_W = 4;

  localparam logic [c_OPC_W-1:0] c_OPC_ADD = 3'd0;
  localparam logic [c_OPC_W-1:0] c_OPC_SUB = 3'd1;
  localparam logic [c_OPC_W-1:0] c_OPC_AND = 3'd2;
  localparam logic [c_OPC_W-1:0] c_OPC_OR  = 3'd3;
  localparam logic [c_OPC_W-1:0] c_OPC_XOR = 3'd4;
  localparam logic [c_OPC_W-1:0] c_OPC_SHL = 3'd5;
  localparam logic [c_OPC_W-1:0] c_OPC_SHR = 3'd6;
  localparam logic [c_OPC_W-1:0] c_OPC_NOT = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Purpose : Combinational round-robin picker; searches from i_ptr upwards.
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_any
);

  always_comb begin : p_pick
    int w_j;
    w_j       = 0;
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_j = (int'(i_ptr) + k) % N;
      if (!o_any && i_req[w_j]) begin
        o_any     = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_gnt_idx = IDX_W'(w_j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : alu_arbiter
// Purpose : Round-robin sharing of one alu between N_REQ requesters.
// Revision: 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int OP_W    = c_OP_W,
  parameter int OPC_W   = c_OPC_W,
  parameter int RES_W   = c_RES_W,
  parameter int ALU_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*OP_W-1:0]  req_op1,
  input  logic [N_REQ*OP_W-1:0]  req_op2,
  input  logic [N_REQ*OPC_W-1:0] req_opcode,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [RES_W-1:0]       rsp_result,
  output logic [OP_W-1:0]        alu_op1,
  output logic [OP_W-1:0]        alu_op2,
  output logic [OPC_W-1:0]       alu_opcode,
  input  logic [RES_W-1:0]       alu_result
);

  localparam int c_IDX_W = $clog2(N_REQ);
  localparam int c_LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_IDX_W-1:0]   r_rr_ptr;
  logic [c_IDX_W-1:0]   r_owner;
  logic [c_IDX_W-1:0]   w_ptr_nxt;
  logic [c_LAT_W-1:0]   r_lat_cnt;
  logic [OP_W-1:0]      r_alu_op1;
  logic [OP_W-1:0]      r_alu_op2;
  logic [OPC_W-1:0]     r_alu_opcode;
  logic [RES_W-1:0]     r_rsp_result;

  logic [N_REQ-1:0]     w_gnt;
  logic [c_IDX_W-1:0]   w_gnt_idx;
  logic                 w_any;
  logic                 w_accept;
  logic                 w_lat_done;
  logic                 w_rsp_done;
  logic [N_REQ-1:0]     w_owner_oh;

  logic [OP_W-1:0]      w_op1 [N_REQ];
  logic [OP_W-1:0]      w_op2 [N_REQ];
  logic [OPC_W-1:0]     w_opc [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_op1[gi] = req_op1[gi*OP_W +: OP_W];
      assign w_op2[gi] = req_op2[gi*OP_W +: OP_W];
      assign w_opc[gi] = req_opcode[gi*OPC_W +: OPC_W];
    end
  endgenerate

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (c_IDX_W)
  ) u_rr_pick (
    .i_req     (req_valid),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  assign w_accept   = (r_state == ST_IDLE) && w_any;
  assign w_lat_done = (r_state == ST_EXEC) && (r_lat_cnt == '0);
  assign w_rsp_done = (r_state == ST_RESP) && rsp_ready[r_owner];
  assign w_ptr_nxt  = (r_owner == c_IDX_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)   w_state_nxt = ST_EXEC;
      ST_EXEC: if (w_lat_done) w_state_nxt = ST_RESP;
      ST_RESP: if (w_rsp_done) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // alu inputs only change on accept, so the alu sees stable operands throughout EXEC
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_lat_cnt    <= '0;
      r_alu_op1    <= '0;
      r_alu_op2    <= '0;
      r_alu_opcode <= '0;
      r_rsp_result <= '0;
    end else begin
      if (w_accept) begin
        r_alu_op1    <= w_op1[w_gnt_idx];
        r_alu_op2    <= w_op2[w_gnt_idx];
        r_alu_opcode <= w_opc[w_gnt_idx];
        r_owner      <= w_gnt_idx;
        r_lat_cnt    <= c_LAT_W'(ALU_LAT - 1);
      end
      if (r_state == ST_EXEC) begin
        if (r_lat_cnt == '0) begin
          r_rsp_result <= alu_result;
        end else begin
          r_lat_cnt <= r_lat_cnt - 1'b1;
        end
      end
      if (w_rsp_done) begin
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  // Grant is masked while reset is held so nothing looks accepted during reset
  assign req_ready  = ((r_state == ST_IDLE) && rstn) ? w_gnt : '0;
  assign rsp_valid  = (r_state == ST_RESP) ? w_owner_oh : '0;
  assign rsp_result = r_rsp_result;
  assign alu_op1    = r_alu_op1;
  assign alu_op2    = r_alu_op2;
  assign alu_opcode = r_alu_opcode;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_arbiter
// Purpose : Randomised scoreboard bench for alu_arbiter with a behavioural alu.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N       = 4;
  localparam int OP_W    = 4;
  localparam int OPC_W   = 3;
  localparam int RES_W   = 4;
  localparam int ALU_LAT = 2;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N*OP_W-1:0]    req_op1;
  logic [N*OP_W-1:0]    req_op2;
  logic [N*OPC_W-1:0]   req_opcode;
  logic [N-1:0]         rsp_valid;
  logic [N-1:0]         rsp_ready;
  logic [RES_W-1:0]     rsp_result;
  logic [OP_W-1:0]      alu_op1;
  logic [OP_W-1:0]      alu_op2;
  logic [OPC_W-1:0]     alu_opcode;
  logic [RES_W-1:0]     alu_result;
  logic [RES_W-1:0]     alu_q;

  alu_arbiter #(
    .N_REQ(N), .OP_W(OP_W), .OPC_W(OPC_W), .RES_W(RES_W), .ALU_LAT(ALU_LAT)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_opcode(req_opcode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opcode(alu_opcode),
    .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  function automatic logic [RES_W-1:0] alu_f(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                             input logic [OPC_W-1:0] opc);
    case (opc)
      c_OPC_ADD: return a + b;
      c_OPC_SUB: return a - b;
      c_OPC_AND: return a & b;
      c_OPC_OR:  return a | b;
      c_OPC_XOR: return a ^ b;
      c_OPC_SHL: return a << 1;
      c_OPC_SHR: return a >> 1;
      default:   return ~a;
    endcase
  endfunction

  // Two-cycle alu: one input-register stage is in the DUT, one here
  always @(posedge clk) alu_q <= alu_f(alu_op1, alu_op2, alu_opcode);
  assign alu_result = alu_q;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct { int id; logic [RES_W-1:0] res; int due; } exp_t;
  exp_t             q[$];
  int               g_log[$];
  int               cyc = 0;
  bit               m_busy = 0;
  int               m_ptr = 0;
  logic [OP_W-1:0]  m_op1 = '0;
  logic [OP_W-1:0]  m_op2 = '0;
  logic [OPC_W-1:0] m_opc = '0;
  logic [N-1:0]     hs_mask = '0;
  int               other_cnt = 0;

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  always @(negedge clk) begin : monitor
    logic [N-1:0] exp_rdy;
    logic [N-1:0] obs;
    int           w;
    exp_t         e;
    cyc++;
    if (!rstn) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_alu_ops", {alu_op1, alu_op2, alu_opcode}, 0);
      q.delete(); g_log.delete();
      m_busy = 0; m_ptr = 0; m_op1 = '0; m_op2 = '0; m_opc = '0;
      hs_mask = '0; other_cnt = 0;
    end else begin
      exp_rdy = '0;
      w = -1;
      if (!m_busy && req_valid != '0) begin
        w = pick(req_valid, m_ptr);
        exp_rdy[w] = 1'b1;
      end
      chk("req_ready", req_ready, exp_rdy);
      chk("alu_ops_hold", {alu_op1, alu_op2, alu_opcode}, {m_op1, m_op2, m_opc});
      obs = req_valid & req_ready;
      hs_mask = obs;
      if (obs != '0) begin
        for (int i = 0; i < N; i++) if (obs[i]) g_log.push_back(i);
        if (obs[N-1]) begin
          chk("fair3_wait", other_cnt < N, 1);
          other_cnt = 0;
        end else if (req_valid[N-1]) other_cnt++;
      end
      if (!req_valid[N-1]) other_cnt = 0;
      if (q.size() > 0 && cyc >= q[0].due) begin
        chk("rsp_valid", rsp_valid, N'(1) << q[0].id);
        chk("rsp_result", rsp_result, q[0].res);
        if (rsp_valid[q[0].id] && rsp_ready[q[0].id]) begin
          m_ptr = (q[0].id + 1) % N;
          void'(q.pop_front());
          m_busy = 0;
        end
      end else begin
        chk("rsp_idle", rsp_valid, 0);
      end
      if (w >= 0) begin
        m_op1 = req_op1[w*OP_W +: OP_W];
        m_op2 = req_op2[w*OP_W +: OP_W];
        m_opc = req_opcode[w*OPC_W +: OPC_W];
        e.id = w; e.res = alu_f(m_op1, m_op2, m_opc); e.due = cyc + 1 + ALU_LAT;
        q.push_back(e);
        m_busy = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  int p_valid[N];
  int p_rdy;

  task automatic set_req(input int i, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                         input logic [OPC_W-1:0] c);
    req_valid[i] = 1'b1;
    req_op1[i*OP_W +: OP_W] = a;
    req_op2[i*OP_W +: OP_W] = b;
    req_opcode[i*OPC_W +: OPC_W] = c;
  endtask

  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (hs_mask[i]) req_valid[i] = 1'b0;
      if (!req_valid[i] && ($urandom_range(99) < p_valid[i]))
        set_req(i, OP_W'($urandom), OP_W'($urandom), OPC_W'($urandom));
      rsp_ready[i] = ($urandom_range(99) < p_rdy);
    end
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < N; i++) p_valid[i] = 0;
    p_rdy = 100;
    for (int k = 0; k < 200; k++) begin
      step();
      if (req_valid == '0 && !m_busy) begin ok = 1; break; end
    end
    chk("drain_done", ok, 1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ok;
    int n;
    rstn = 1'b0; req_valid = '1; rsp_ready = '1; p_rdy = 100;
    req_op1 = '0; req_op2 = '0; req_opcode = '0;
    for (int i = 0; i < N; i++) p_valid[i] = 100;
    // reset with all requesters asking, then round-robin order after release
    @(posedge clk); #1; @(posedge clk); #1;
    rstn = 1'b1;
    ok = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (g_log.size() >= 5) begin ok = 1; break; end
    end
    chk("rr_5_grants", ok, 1);
    if (ok) begin
      chk("rr_g0", g_log[0], 0); chk("rr_g1", g_log[1], 1); chk("rr_g2", g_log[2], 2);
      chk("rr_g3", g_log[3], 3); chk("rr_g4", g_log[4], 0);
    end
    drain();

    // single directed op on requester 0
    set_req(0, 4'hF, 4'h0, 3'b111);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (hs_mask[0]) begin ok = 1; break; end
    end
    chk("t2_accept", ok, 1);
    chk("t2_alu_op1", alu_op1, 4'hF);
    chk("t2_alu_op2", alu_op2, 4'h0);
    chk("t2_alu_opc", alu_opcode, 3'd7);
    n = 0;
    while (!rsp_valid[0] && n < 20) begin step(); n++; end
    chk("t2_latency", n, ALU_LAT);
    chk("t2_result", rsp_result, alu_f(4'hF, 4'h0, 3'd7));
    drain();

    // backpressure on requester 1
    p_rdy = 0;
    set_req(1, 4'h9, 4'h5, c_OPC_ADD);
    n = 0;
    while (!rsp_valid[1] && n < 20) begin step(); n++; end
    chk("bp_rsp_seen", rsp_valid[1], 1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_valid", rsp_valid, 4'b0010);
      chk("bp_hold_result", rsp_result, 4'hE);
      chk("bp_no_ready", req_ready, 0);
    end
    drain();

    // reset while EXEC: pointer returns to 0, lowest valid wins afterwards
    set_req(0, 4'h3, 4'h4, c_OPC_XOR);
    set_req(2, 4'h7, 4'h1, c_OPC_SUB);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (hs_mask != '0) begin ok = 1; break; end
    end
    chk("rx_grant_seen", hs_mask, 4'b0100);
    rstn = 1'b0;
    step(); step();
    set_req(2, 4'h7, 4'h1, c_OPC_SUB);
    rstn = 1'b1;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (hs_mask != '0) begin ok = 1; break; end
    end
    chk("rx_next_grant", hs_mask, 4'b0001);
    drain();

    // fairness: requester 3 always asking, others random
    p_valid[0] = 40; p_valid[1] = 40; p_valid[2] = 40; p_valid[3] = 100; p_rdy = 70;
    for (int k = 0; k < 300; k++) step();
    drain();

    // fully random traffic
    for (int i = 0; i < N; i++) p_valid[i] = 50;
    p_rdy = 60;
    for (int k = 0; k < 400; k++) step();
    drain();
    chk("scoreboard_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
